player_move_scheduler: RTL and testbench
========================================

Name: player_move_scheduler

Overview:
Sequences the per-frame movement of the player sprite. Samples the left/right keys once per video frame and emits a burst of single-cycle enable pulses with qualified left/right directions into the player position datapath. Adds hold-to-accelerate behaviour (more steps per frame the longer a direction is held) and a pause toggle. Sits between the key inputs / VGA frame timing and the player position register.

Parameters:
ACCEL_FRAMES, 4, consecutive same-direction frames per speed increment (>=1)
MAX_SPEED, 4, maximum enable pulses per frame (1..7)
PULSE_GAP, 1, idle cycles between consecutive enable pulses in a burst (0 = back-to-back)
DEBOUNCE_CYCLES, 16, stable cycles required per key (only with PLAYER_MOVE_DEBOUNCE_EN)

Ports:
CLOCK_50  input  1  system clock, all logic on rising edge
global_reset_n  input  1  asynchronous active-low reset
frame_start  input  1  one-cycle pulse per frame, synchronous to CLOCK_50
key_left  input  1  raw left key, active-high, asynchronous
key_right  input  1  raw right key, active-high, asynchronous
pause_toggle  input  1  one-cycle pulse; flips paused state
enable  output  1  step strobe to position datapath
left  output  1  step left; valid only while enable=1, else 0
right  output  1  step right; valid only while enable=1, else 0
speed  output  3  current speed level (pulses per frame)
busy  output  1  high while a burst is in progress
paused  output  1  paused state
overrun  output  1  sticky: frame_start arrived while burst incomplete

Behaviour:
- Reset (async, global_reset_n=0): state IDLE; enable=left=right=busy=paused=overrun=0; speed=1; accel_cnt=0; prev_dir=NONE; synchronizers cleared.
- key_left/key_right pass through 2-FF synchronizers; synchronized level is the sampled value (2-cycle input latency).
- Direction at frame_start: LEFT if only left held, RIGHT if only right held, else NONE.
- Speed update on each frame_start (not paused):
  - NONE: speed=1, accel_cnt=0, prev_dir=NONE, no burst.
  - Dir differs from prev_dir: speed=1, accel_cnt=0, burst length 1.
  - Dir equals prev_dir: accel_cnt+1; on reaching ACCEL_FRAMES, accel_cnt=0 and speed=min(speed+1, MAX_SPEED); burst length = new speed.
  - prev_dir <= dir.
- FSM states IDLE, PULSE, GAP:
  - IDLE -> PULSE on the cycle after frame_start with burst length >=1; burst direction latched.
  - PULSE: enable=1 for one cycle with latched left/right; remaining count -1; go to GAP if PULSE_GAP>0 and pulses remain, PULSE if PULSE_GAP=0 and pulses remain, IDLE when last pulse issued.
  - GAP: hold PULSE_GAP cycles, then PULSE.
  - busy=1 in PULSE and GAP.
- frame_start while busy: remaining pulses dropped, overrun set (cleared only by reset), new frame sampled and new burst starts the next cycle as from IDLE.
- pause_toggle: paused flips. Entering pause aborts any burst (back to IDLE next cycle), resets speed=1, accel_cnt=0, prev_dir=NONE. While paused frame_start is ignored and enable stays 0.
- pause_toggle coincident with frame_start: pause takes priority; the frame is not sampled if the result is paused.
- enable never asserted with left and right both high; at most speed pulses per frame.

Optional Feature:
PLAYER_MOVE_DEBOUNCE_EN: when defined, each synchronized key feeds a debouncer; its filtered level changes only after DEBOUNCE_CYCLES consecutive cycles at the new value, and frame sampling uses the filtered level. When undefined, synchronized levels are used directly and DEBOUNCE_CYCLES is unused.

Test Plan:
- Reset mid-burst (speed=3, busy=1), assert global_reset_n=0 between clock edges -> all outputs 0 and speed=1 immediately, without waiting for a clock edge.
- Hold key_left for 6 frames, ACCEL_FRAMES=4, PULSE_GAP=1 -> frames 1-4 give 1 enable pulse each, frames 5-6 give 2 pulses each on alternate cycles, with left=1 during enable and speed=2 from frame 5.
- Hold key_right 20 frames, MAX_SPEED=4 -> speed saturates at 4 and stays there, 4 pulses per frame; both keys held the next frame -> 0 pulses and speed=1.
- Switch from left to right after speed=3 -> the next frame gives 1 right pulse, speed=1.
- PULSE_GAP=3, speed=4, frame_start again 5 cycles into the burst -> remaining pulses dropped, overrun=1, new burst starts 1 cycle later.
- pause_toggle during a burst -> enable=0 from the next cycle; frame_start for 3 frames gives no pulses; pause_toggle again then key_left held -> 1 pulse, speed=1.

Source files
------------

// File: rtl/player_move_scheduler_if.sv
// Bundle between the key / frame-timing side and the player move scheduler.
// Signalling: frame_start and pause_toggle are single-cycle strobes, sampled on
// the rising clock edge. enable is a single-cycle step strobe. left/right are
// meaningful only while enable=1 and are held at 0 otherwise. There is no
// back-pressure: the position datapath must take every step the cycle it is
// offered. dbg_state exposes the scheduler FSM state for observation.
interface player_move_scheduler_if;
  logic       frame_start;
  logic       key_left;
  logic       key_right;
  logic       pause_toggle;
  logic       enable;
  logic       left;
  logic       right;
  logic [2:0] speed;
  logic       busy;
  logic       paused;
  logic       overrun;
  logic [1:0] dbg_state;

  // Driver of keys and frame timing
  modport master (
    output frame_start, key_left, key_right, pause_toggle,
    input  enable, left, right, speed, busy, paused, overrun, dbg_state
  );

  // The scheduler itself
  modport slave (
    input  frame_start, key_left, key_right, pause_toggle,
    output enable, left, right, speed, busy, paused, overrun, dbg_state
  );
endinterface

// File: rtl/player_move_scheduler.sv
// Player move scheduler: samples left/right once per frame and issues a burst
// of single-cycle step strobes whose length grows while a direction is held.
// Pause toggle aborts bursts and resets acceleration.
// Optional key debouncing is enabled by defining PLAYER_MOVE_DEBOUNCE_EN.
module player_move_scheduler #(
  parameter int ACCEL_FRAMES    = 4,
  parameter int MAX_SPEED       = 4,
  parameter int PULSE_GAP       = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                     CLOCK_50,
  input  logic                     global_reset_n,
  player_move_scheduler_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_RIGHT = 2'd2
  } dir_t;

  // accel counter runs 0..ACCEL_FRAMES-1; wrapping at ACC_LAST bumps speed
  localparam int             AW       = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [AW-1:0]  ACC_LAST = AW'(ACCEL_FRAMES - 1);
  localparam int             GW       = (PULSE_GAP > 1) ? $clog2(PULSE_GAP) : 1;
  localparam logic [GW-1:0]  GAP_LOAD = GW'((PULSE_GAP > 0) ? PULSE_GAP - 1 : 0);
  localparam logic [2:0]     SPD_MAX  = 3'(MAX_SPEED);

  // bit 0 = left, bit 1 = right
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] keys_lvl;

  state_t        state_q, state_d;
  dir_t          prev_q, prev_d;
  dir_t          bdir_q, bdir_d;
  dir_t          dir;
  logic [2:0]    speed_q, speed_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [2:0]    rem_q, rem_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          paused_q, paused_d;
  logic          overrun_q, overrun_d;
  logic [2:0]    len;

  // Two-flop synchronizers for the asynchronous key inputs
  always_ff @(posedge CLOCK_50 or negedge global_reset_n) begin
    if (!global_reset_n) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
    end else begin
      sync1_q <= {bus.key_right, bus.key_left};
      sync2_q <= sync1_q;
    end
  end

`ifdef PLAYER_MOVE_DEBOUNCE_EN
  localparam int            DW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    filt_q, filt_d;
  logic [DW-1:0] db_cnt_q [2];
  logic [DW-1:0] db_cnt_d [2];

  // Filtered level flips only after DEBOUNCE_CYCLES consecutive differing cycles
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i]   = filt_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) filt_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  // Debouncer state registers
  always_ff @(posedge CLOCK_50 or negedge global_reset_n) begin
    if (!global_reset_n) begin
      filt_q      <= 2'b00;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      filt_q      <= filt_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
    end
  end

  assign keys_lvl = filt_q;
`else
  // DEBOUNCE_CYCLES only matters to the filter build
  logic unused_debounce;
  assign unused_debounce = |DEBOUNCE_CYCLES;
  assign keys_lvl        = sync2_q;
`endif

  // Frame direction: exactly one key held selects it, otherwise none
  always_comb begin
    dir = DIR_NONE;
    if (keys_lvl == 2'b01)      dir = DIR_LEFT;
    else if (keys_lvl == 2'b10) dir = DIR_RIGHT;
  end

  // State and datapath registers
  always_ff @(posedge CLOCK_50 or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q   <= ST_IDLE;
      prev_q    <= DIR_NONE;
      bdir_q    <= DIR_NONE;
      speed_q   <= 3'd1;
      acc_q     <= '0;
      rem_q     <= 3'd0;
      gap_q     <= '0;
      paused_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      bdir_q    <= bdir_d;
      speed_q   <= speed_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      paused_q  <= paused_d;
      overrun_q <= overrun_d;
    end
  end

  // Next state: pause entry beats a frame, a frame beats burst progress
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    bdir_d    = bdir_q;
    speed_d   = speed_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    paused_d  = paused_q ^ bus.pause_toggle;
    overrun_d = overrun_q;
    len       = 3'd0;

    if (bus.pause_toggle && !paused_q) begin
      state_d = ST_IDLE;
      speed_d = 3'd1;
      acc_d   = '0;
      prev_d  = DIR_NONE;
      rem_d   = 3'd0;
    end else if (bus.frame_start && !paused_d) begin
      // a frame landing mid-burst drops what is left of it
      if (state_q != ST_IDLE) overrun_d = 1'b1;
      prev_d = dir;
      if (dir == DIR_NONE) begin
        speed_d = 3'd1;
        acc_d   = '0;
        len     = 3'd0;
      end else if (dir != prev_q) begin
        speed_d = 3'd1;
        acc_d   = '0;
        len     = 3'd1;
      end else begin
        if (acc_q == ACC_LAST) begin
          acc_d   = '0;
          speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 3'd1;
        end else begin
          acc_d = acc_q + 1'b1;
        end
        len = speed_d;
      end
      rem_d = len;
      if (len != 3'd0) begin
        bdir_d  = dir;
        state_d = ST_PULSE;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_PULSE: begin
          rem_d = rem_q - 3'd1;
          if (rem_q <= 3'd1) begin
            state_d = ST_IDLE;
          end else if (PULSE_GAP == 0) begin
            state_d = ST_PULSE;
          end else begin
            state_d = ST_GAP;
            gap_d   = GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (gap_q == '0) state_d = ST_PULSE;
          else             gap_d   = gap_q - 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.enable    = (state_q == ST_PULSE);
    bus.left      = (state_q == ST_PULSE) && (bdir_q == DIR_LEFT);
    bus.right     = (state_q == ST_PULSE) && (bdir_q == DIR_RIGHT);
    bus.busy      = (state_q != ST_IDLE);
    bus.speed     = speed_q;
    bus.paused    = paused_q;
    bus.overrun   = overrun_q;
    bus.dbg_state = state_q;
  end

endmodule

// File: tb/tb_player_move_scheduler.sv
// Directed bench for player_move_scheduler: every step pulse is checked
// against an expected-direction queue filled when each frame is driven.
module tb_player_move_scheduler;

  localparam int ACCEL_FRAMES = 4;
  localparam int MAX_SPEED    = 4;
  localparam int PULSE_GAP    = 1;
`ifdef PLAYER_MOVE_DEBOUNCE_EN
  localparam int SETTLE = 22;
`else
  localparam int SETTLE = 3;
`endif

  logic CLOCK_50;
  logic global_reset_n;

  player_move_scheduler_if bus ();

  player_move_scheduler #(
    .ACCEL_FRAMES   (ACCEL_FRAMES),
    .MAX_SPEED      (MAX_SPEED),
    .PULSE_GAP      (PULSE_GAP),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .global_reset_n(global_reset_n),
    .bus           (bus)
  );

  // Clock
  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  int         tests_run;
  int         tests_failed;
  int         cyc;
  int         last_cyc;
  bit         last_valid;
  int         pulse_total;
  logic [1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: runs once per cycle at the falling edge
  task automatic observe();
    logic [1:0] e;
    cyc++;
    if (bus.enable === 1'b1) begin
      chk("lr_exclusive", 32'(bus.left & bus.right), 32'd0);
      tests_run++;
      assert (exp_q.size() != 0) else begin
        tests_failed++;
        $error("FAIL unexpected_pulse: observed lr=%b expected no pulse", {bus.left, bus.right});
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pulse_dir", 32'({bus.left, bus.right}), 32'(e));
      end
      if (last_valid) chk("pulse_spacing", 32'(cyc - last_cyc), 32'(PULSE_GAP + 1));
      last_cyc    = cyc;
      last_valid  = 1'b1;
      pulse_total++;
    end
    if (bus.busy !== 1'b1) last_valid = 1'b0;
  endtask

  // One clock: observe this cycle, then land 1 ns after the next rising edge
  task automatic step();
    @(negedge CLOCK_50);
    observe();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy === 1'b1 && k < 40) begin
      step();
      k++;
    end
    chk("burst_done", 32'(bus.busy), 32'd0);
  endtask

  // Hold keys, fire one frame, check burst length, queue drain and speed
  task automatic frame(input logic l, input logic r, input int n, input int spd);
    int base;
    bus.key_left  = l;
    bus.key_right = r;
    repeat (SETTLE) step();
    for (int i = 0; i < n; i++) exp_q.push_back({l, r});
    base = pulse_total;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    wait_idle();
    step();
    chk("frame_pulses", 32'(pulse_total - base), 32'(n));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("frame_speed", 32'(bus.speed), 32'(spd));
  endtask

  initial begin
    int left_spd [9];
    int ramp_spd [8];
    tests_run    = 0;
    tests_failed = 0;
    cyc          = 0;
    last_cyc     = 0;
    last_valid   = 1'b0;
    pulse_total  = 0;
    left_spd     = '{1, 1, 1, 1, 2, 2, 2, 2, 3};
    ramp_spd     = '{1, 1, 1, 1, 2, 2, 2, 2};

    global_reset_n   = 1'b0;
    bus.frame_start  = 1'b0;
    bus.key_left     = 1'b0;
    bus.key_right    = 1'b0;
    bus.pause_toggle = 1'b0;
    @(posedge CLOCK_50);
    #1;
    chk("rst_enable", 32'(bus.enable), 32'd0);
    chk("rst_left", 32'(bus.left), 32'd0);
    chk("rst_right", 32'(bus.right), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_paused", 32'(bus.paused), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    chk("rst_speed", 32'(bus.speed), 32'd1);
    chk("rst_state", 32'(bus.dbg_state), 32'd0);
    global_reset_n = 1'b1;
    repeat (3) step();

    // Hold left: 1 pulse for 4 frames, 2 for the next 4, then speed 3
    for (int f = 0; f < 9; f++) frame(1'b1, 1'b0, left_spd[f], left_spd[f]);

    // Switch to right: back to a single pulse, then ramp and saturate at 4
    for (int f = 1; f <= 20; f++) begin
      int s;
      s = 1 + (f - 1) / ACCEL_FRAMES;
      if (s > MAX_SPEED) s = MAX_SPEED;
      frame(1'b0, 1'b1, s, s);
    end

    // Frame arriving mid-burst: two pulses out, rest dropped, new burst next cycle
    repeat (SETTLE) step();
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b01);
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    repeat (3) step();
    chk("ovr_busy_before", 32'(bus.busy), 32'd1);
    chk("ovr_flag_before", 32'(bus.overrun), 32'd0);
    for (int i = 0; i < 4; i++) exp_q.push_back(2'b01);
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    chk("ovr_flag", 32'(bus.overrun), 32'd1);
    chk("ovr_new_pulse", 32'(bus.enable), 32'd1);
    wait_idle();
    step();
    chk("ovr_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("ovr_speed", 32'(bus.speed), 32'd4);

    // Both keys held: no burst, speed back to 1
    frame(1'b1, 1'b1, 0, 1);

    // Pause during a two-pulse burst
    for (int f = 0; f < 4; f++) frame(1'b1, 1'b0, 1, 1);
    repeat (SETTLE) step();
    exp_q.push_back(2'b10);
    bus.frame_start = 1'b1;
    step();
    bus.frame_start  = 1'b0;
    bus.pause_toggle = 1'b1;
    step();
    bus.pause_toggle = 1'b0;
    chk("pause_enable", 32'(bus.enable), 32'd0);
    chk("pause_busy", 32'(bus.busy), 32'd0);
    chk("pause_flag", 32'(bus.paused), 32'd1);
    chk("pause_speed", 32'(bus.speed), 32'd1);
    repeat (6) step();
    chk("pause_queue_empty", 32'(exp_q.size()), 32'd0);
    for (int f = 0; f < 3; f++) frame(1'b1, 1'b0, 0, 1);
    bus.pause_toggle = 1'b1;
    step();
    bus.pause_toggle = 1'b0;
    chk("unpause_flag", 32'(bus.paused), 32'd0);
    frame(1'b1, 1'b0, 1, 1);

    // Pause toggle coincident with frame: entering pause drops the frame
    bus.pause_toggle = 1'b1;
    bus.frame_start  = 1'b1;
    step();
    bus.pause_toggle = 1'b0;
    bus.frame_start  = 1'b0;
    chk("coinc_pause_flag", 32'(bus.paused), 32'd1);
    chk("coinc_pause_busy", 32'(bus.busy), 32'd0);
    repeat (4) step();
    // Leaving pause on a frame edge samples that frame
    exp_q.push_back(2'b10);
    bus.pause_toggle = 1'b1;
    bus.frame_start  = 1'b1;
    step();
    bus.pause_toggle = 1'b0;
    bus.frame_start  = 1'b0;
    chk("coinc_unpause_flag", 32'(bus.paused), 32'd0);
    chk("coinc_unpause_busy", 32'(bus.busy), 32'd1);
    wait_idle();
    step();
    chk("coinc_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset in the middle of a speed-3 burst
    frame(1'b0, 1'b0, 0, 1);
    for (int f = 0; f < 8; f++) frame(1'b1, 1'b0, ramp_spd[f], ramp_spd[f]);
    repeat (SETTLE) step();
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_speed", 32'(bus.speed), 32'd3);
    #2;
    global_reset_n = 1'b0;
    #1;
    chk("async_enable", 32'(bus.enable), 32'd0);
    chk("async_left", 32'(bus.left), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    chk("async_overrun", 32'(bus.overrun), 32'd0);
    chk("async_paused", 32'(bus.paused), 32'd0);
    chk("async_speed", 32'(bus.speed), 32'd1);
    #2;
    global_reset_n = 1'b1;
    @(posedge CLOCK_50);
    #1;
    last_valid = 1'b0;
    frame(1'b1, 1'b0, 1, 1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
